// File: rtl/bcd_down_counter.sv
// -----------------------------------------------------------------------------
// bcd_down_counter
//
// Multi-digit BCD countdown timer. A load captures a BCD preset (each digit
// above 9 is clamped to 9), then every enabled cycle in RUN subtracts one,
// borrowing decimally between digits. Reaching zero moves the counter to DONE
// and emits a single-cycle done pulse.
//
// Optional build macro:
//   AUTO_RELOAD_EN - at terminal count the counter reloads the last preset and
//                    keeps running instead of halting; done still pulses once
//                    per period.
//
// Parameters:
//   DIGITS   number of BCD digits (1..8); count is 4*DIGITS bits wide.
//
// Ports:
//   clk       in   rising-edge clock
//   clear     in   asynchronous active-high reset
//   load      in   synchronous load strobe (beats en)
//   load_val  in   BCD preset, digit 0 in bits [3:0]
//   en        in   count enable, honoured only in RUN
//   count     out  registered BCD count
//   busy      out  high while in RUN
//   zero      out  high while count is zero
//   done      out  one-cycle pulse when terminal count is reached
// -----------------------------------------------------------------------------
module bcd_down_counter #(
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  en,
    output logic [4*DIGITS-1:0]   count,
    output logic                  busy,
    output logic                  zero,
    output logic                  done
);

    localparam int W = 4 * DIGITS;
    localparam logic [W-1:0] BCD_ONE = W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Clamp every digit to the BCD range so downstream display logic never
    // sees a non-decimal digit.
    function automatic logic [W-1:0] bcd_sanitise(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic [3:0]   d;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            d = v[4*i +: 4];
            r[4*i +: 4] = (d > 4'd9) ? 4'd9 : d;
        end
        return r;
    endfunction

    // Subtract one with a decimal borrow rippling from digit 0 upward. Only
    // used for counts of two or more, so the top digit never underflows.
    function automatic logic [W-1:0] bcd_decrement(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic [3:0]   d;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            d = v[4*i +: 4];
            if (borrow) begin
                if (d == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = d - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    state_t         state_q, state_d;
    logic [W-1:0]   count_q, count_d;
    logic           done_q,  done_d;
    logic [W-1:0]   load_bcd;

`ifdef AUTO_RELOAD_EN
    logic [W-1:0]   preset_q, preset_d;
`endif

    assign load_bcd = bcd_sanitise(load_val);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        done_d  = 1'b0;
`ifdef AUTO_RELOAD_EN
        preset_d = preset_q;
`endif
        if (load) begin
            // A zero preset goes straight to DONE without a done pulse.
            count_d = load_bcd;
            state_d = (load_bcd == '0) ? ST_DONE : ST_RUN;
`ifdef AUTO_RELOAD_EN
            preset_d = load_bcd;
`endif
        end else if (state_q == ST_RUN && en) begin
            if (count_q == BCD_ONE) begin
                done_d = 1'b1;
`ifdef AUTO_RELOAD_EN
                // Reload instead of passing through zero: period == preset.
                count_d = preset_q;
`else
                count_d = '0;
                state_d = ST_DONE;
`endif
            end else begin
                count_d = bcd_decrement(count_q);
            end
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

`ifdef AUTO_RELOAD_EN
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            preset_q <= '0;
        end else begin
            preset_q <= preset_d;
        end
    end
`endif

    assign count = count_q;
    assign busy  = (state_q == ST_RUN);
    assign zero  = (count_q == '0);
    assign done  = done_q;

endmodule

// File: tb/tb_bcd_down_counter.sv
// -----------------------------------------------------------------------------
// tb_bcd_down_counter
//
// Bench for bcd_down_counter with DIGITS=2: a directed vector table, a few
// hand-written multi-cycle sequences (long countdown, preset 3 run-out,
// clear between edges) and a randomized phase checked against an
// integer-arithmetic reference model. Honours AUTO_RELOAD_EN.
// -----------------------------------------------------------------------------
module tb_bcd_down_counter;

    localparam int DIGITS = 2;
    localparam int W      = 4 * DIGITS;

    logic         clk = 1'b0;
    logic         clear;
    logic         load;
    logic [W-1:0] load_val;
    logic         en;
    logic [W-1:0] count;
    logic         busy;
    logic         zero;
    logic         done;

    int n_chk  = 0;
    int n_fail = 0;

    bcd_down_counter #(.DIGITS(DIGITS)) dut (
        .clk      (clk),
        .clear    (clear),
        .load     (load),
        .load_val (load_val),
        .en       (en),
        .count    (count),
        .busy     (busy),
        .zero     (zero),
        .done     (done)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (decimal integers) ----------------
    int m_val;     // counter value as a plain integer
    int m_state;   // 0 idle, 1 run, 2 done
    int m_preset;
    bit m_done;

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int           x;
        r = '0;
        x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int clamp_value(input logic [W-1:0] lv);
        int v;
        int p;
        int d;
        v = 0;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            d = int'(lv[4*i +: 4]);
            if (d > 9) d = 9;
            v = v + d * p;
            p = p * 10;
        end
        return v;
    endfunction

    task automatic model_step(input logic c, input logic l, input logic [W-1:0] lv, input logic e);
        int v;
        if (c) begin
            m_val = 0; m_state = 0; m_done = 0; m_preset = 0;
        end else if (l) begin
            v = clamp_value(lv);
            m_val = v; m_preset = v; m_done = 0;
            m_state = (v != 0) ? 1 : 2;
        end else if (m_state == 1 && e) begin
            if (m_val == 1) begin
                m_done = 1;
`ifdef AUTO_RELOAD_EN
                m_val = m_preset;
`else
                m_val = 0;
                m_state = 2;
`endif
            end else begin
                m_val = m_val - 1;
                m_done = 0;
            end
        end else begin
            m_done = 0;
        end
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_outputs(input string tag, input logic [W-1:0] c, input logic b,
                               input logic z, input logic d);
        chk({tag, ".count"}, 32'(count), 32'(c));
        chk({tag, ".busy"},  32'(busy),  32'(b));
        chk({tag, ".zero"},  32'(zero),  32'(z));
        chk({tag, ".done"},  32'(done),  32'(d));
    endtask

    task automatic chk_model(input string tag);
        chk_outputs(tag, to_bcd(m_val), (m_state == 1), (m_val == 0), m_done);
    endtask

    // Drive inputs, take one clock edge, update the model, settle.
    task automatic step(input logic c, input logic l, input logic [W-1:0] lv, input logic e);
        clear = c; load = l; load_val = lv; en = e;
        @(posedge clk);
        model_step(c, l, lv, e);
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic         clr;
        logic         ld;
        logic [W-1:0] lv;
        logic         en;
        logic [W-1:0] c;
        logic         b;
        logic         z;
        logic         d;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    task automatic set_vec(input int i, input logic clr, input logic ld, input logic [W-1:0] lv,
                           input logic e, input logic [W-1:0] c, input logic b, input logic z,
                           input logic d);
        vecs[i].clr = clr; vecs[i].ld = ld; vecs[i].lv = lv; vecs[i].en = e;
        vecs[i].c = c; vecs[i].b = b; vecs[i].z = z; vecs[i].d = d;
    endtask

    initial begin
        int e_val;
        bit e_done;
        logic [W-1:0] lv;

        clear = 1'b1; load = 1'b0; load_val = '0; en = 1'b0;
        m_val = 0; m_state = 0; m_done = 0; m_preset = 0;

        //        idx clr ld lv     en  count  busy zero done
        set_vec( 0, 1, 0, 8'h00, 0, 8'h00, 0, 1, 0);  // reset state
        set_vec( 1, 0, 0, 8'h00, 1, 8'h00, 0, 1, 0);  // IDLE ignores en
        set_vec( 2, 0, 1, 8'h07, 0, 8'h07, 1, 0, 0);
        set_vec( 3, 0, 0, 8'h00, 1, 8'h06, 1, 0, 0);
        set_vec( 4, 0, 0, 8'h00, 0, 8'h06, 1, 0, 0);  // hold
        set_vec( 5, 0, 0, 8'h00, 0, 8'h06, 1, 0, 0);
        set_vec( 6, 0, 0, 8'h00, 1, 8'h05, 1, 0, 0);
        set_vec( 7, 0, 0, 8'h00, 1, 8'h04, 1, 0, 0);
        set_vec( 8, 0, 1, 8'hAF, 0, 8'h99, 1, 0, 0);  // both digits clamped
        set_vec( 9, 0, 0, 8'h00, 1, 8'h98, 1, 0, 0);
        set_vec(10, 0, 1, 8'h00, 0, 8'h00, 0, 1, 0);  // zero load -> DONE, no pulse
        set_vec(11, 0, 0, 8'h00, 1, 8'h00, 0, 1, 0);
        set_vec(12, 0, 1, 8'h30, 1, 8'h30, 1, 0, 0);  // load beats en
        set_vec(13, 0, 0, 8'h00, 1, 8'h29, 1, 0, 0);  // borrow 30 -> 29
        set_vec(14, 0, 1, 8'h01, 0, 8'h01, 1, 0, 0);
`ifdef AUTO_RELOAD_EN
        set_vec(15, 0, 0, 8'h00, 1, 8'h01, 1, 0, 1);  // preset 1 reloads every cycle
        set_vec(16, 0, 0, 8'h00, 1, 8'h01, 1, 0, 1);
`else
        set_vec(15, 0, 0, 8'h00, 1, 8'h00, 0, 1, 1);  // terminal count
        set_vec(16, 0, 0, 8'h00, 1, 8'h00, 0, 1, 0);  // DONE ignores en
`endif
        set_vec(17, 0, 1, 8'h12, 0, 8'h12, 1, 0, 0);  // reload from DONE
        set_vec(18, 0, 0, 8'h00, 1, 8'h11, 1, 0, 0);
        set_vec(19, 1, 0, 8'h00, 1, 8'h00, 0, 1, 0);  // clear

        #2;
        for (int i = 0; i < NV; i++) begin
            step(vecs[i].clr, vecs[i].ld, vecs[i].lv, vecs[i].en);
            chk_outputs($sformatf("vec%0d", i), vecs[i].c, vecs[i].b, vecs[i].z, vecs[i].d);
        end

        // ---- countdown from 25 with en held high ----
        step(0, 1, 8'h25, 0);
        chk_outputs("cd25.load", 8'h25, 1, 0, 0);
        for (int k = 24; k >= 0; k--) begin
            step(0, 0, 8'h00, 1);
`ifdef AUTO_RELOAD_EN
            chk_outputs($sformatf("cd25.%0d", k), (k == 0) ? 8'h25 : to_bcd(k), 1, 0, (k == 0));
`else
            chk_outputs($sformatf("cd25.%0d", k), to_bcd(k), (k != 0), (k == 0), (k == 0));
`endif
        end

        // ---- preset 3 run for 9 enabled cycles ----
        step(0, 1, 8'h03, 0);
        chk_outputs("p3.load", 8'h03, 1, 0, 0);
        for (int j = 1; j <= 9; j++) begin
            step(0, 0, 8'h00, 1);
`ifdef AUTO_RELOAD_EN
            e_val  = 3 - (j % 3);
            e_done = (j % 3 == 0);
`else
            e_val  = (j < 3) ? 3 - j : 0;
            e_done = (j == 3);
`endif
            chk_outputs($sformatf("p3.%0d", j), to_bcd(e_val), (e_val != 0), (e_val == 0), e_done);
        end

        // ---- clear asserted between edges while running ----
        step(0, 1, 8'h14, 0);
        step(0, 0, 8'h00, 1);
        chk_outputs("abort.pre", 8'h13, 1, 0, 0);
        #3;
        clear = 1'b1;
        #1;
        model_step(1, 0, 8'h00, 0);
        chk_outputs("abort.async", 8'h00, 0, 1, 0);
        for (int j = 0; j < 3; j++) begin
            step(0, 0, 8'h00, 1);
            chk_outputs($sformatf("abort.idle%0d", j), 8'h00, 0, 1, 0);
        end

        // ---- randomized traffic against the model ----
        for (int n = 0; n < 400; n++) begin
            lv = W'($urandom);
            if ($urandom_range(0, 3) == 0) lv[3:0] = 4'($urandom_range(0, 2)); // favour short runs
            if ($urandom_range(0, 1) == 0) lv[W-1:4] = '0;
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 9) == 0), lv,
                 ($urandom_range(0, 3) != 0));
            chk_model($sformatf("rnd%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
